// File: rtl/branch_history_table.sv
// Direct-mapped branch history table with 2-bit saturating counters and a
// branch target buffer. It answers the IF-stage fetch PC combinationally and
// learns from outcomes resolved later in the pipeline. It also keeps
// saturating statistics counters for lookups and mispredicts.
// Optional feature: define BHT_BYPASS_EN to forward a same-cycle update to
// the lookup port. Without it, the lookup reads only the registered array.
module branch_history_table #(
  parameter int IDX_BITS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lk_valid,
  input  logic [31:0] lk_pc,
  output logic        pred_hit,
  output logic        pred_taken,
  output logic [31:0] pred_next_pc,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_mispred,
  output logic [15:0] stat_lookups,
  output logic [15:0] stat_mispred
);

  localparam int DEPTH = 1 << IDX_BITS;
  localparam int TAG_W = 30 - IDX_BITS;

  logic              valid_q [DEPTH];
  logic [TAG_W-1:0]  tag_q   [DEPTH];
  logic [31:0]       tgt_q   [DEPTH];
  logic [1:0]        ctr_q   [DEPTH];

  logic [15:0]       stat_lk_q, stat_lk_d;
  logic [15:0]       stat_mp_q, stat_mp_d;

  // The 2-bit counters and the 16-bit statistics counters stop at their end
  // values instead of wrapping around.
  function automatic logic [1:0] ctr_inc(input logic [1:0] c);
    return (c == 2'b11) ? 2'b11 : c + 2'd1;
  endfunction

  function automatic logic [1:0] ctr_dec(input logic [1:0] c);
    return (c == 2'b00) ? 2'b00 : c - 2'd1;
  endfunction

  function automatic logic [15:0] stat_inc(input logic [15:0] s);
    return (s == 16'hFFFF) ? 16'hFFFF : s + 16'd1;
  endfunction

  // Update side: decode the resolved PC. The byte-offset bits never
  // participate.
  logic [IDX_BITS-1:0] u_idx;
  logic [TAG_W-1:0]    u_tag;
  logic                u_hit;
  logic                unused_upd_lsb;

  assign u_idx          = upd_pc[IDX_BITS+1:2];
  assign u_tag          = upd_pc[31:IDX_BITS+2];
  assign u_hit          = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
  assign unused_upd_lsb = ^upd_pc[1:0];

  logic              ent_we_d;
  logic              ent_valid_d;
  logic [TAG_W-1:0]  ent_tag_d;
  logic [31:0]       ent_tgt_d;
  logic [1:0]        ent_ctr_d;

  // Build the post-update image of the addressed entry; a write happens on a
  // hit, or on a taken miss, which allocates the entry as weak-taken.
  always_comb begin
    ent_we_d    = 1'b0;
    ent_valid_d = valid_q[u_idx];
    ent_tag_d   = tag_q[u_idx];
    ent_tgt_d   = tgt_q[u_idx];
    ent_ctr_d   = ctr_q[u_idx];
    if (upd_valid) begin
      if (u_hit) begin
        ent_we_d = 1'b1;
        if (upd_taken) begin
          ent_ctr_d = ctr_inc(ctr_q[u_idx]);
          ent_tgt_d = upd_target;
        end else begin
          ent_ctr_d = ctr_dec(ctr_q[u_idx]);
        end
      end else if (upd_taken) begin
        ent_we_d    = 1'b1;
        ent_valid_d = 1'b1;
        ent_tag_d   = u_tag;
        ent_tgt_d   = upd_target;
        ent_ctr_d   = 2'b10;
      end
    end
  end

  // Array storage. Reset clears all training and takes priority over an
  // update arriving on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        tgt_q[i]   <= 32'd0;
        ctr_q[i]   <= 2'b01;
      end
    end else if (ent_we_d) begin
      valid_q[u_idx] <= ent_valid_d;
      tag_q[u_idx]   <= ent_tag_d;
      tgt_q[u_idx]   <= ent_tgt_d;
      ctr_q[u_idx]   <= ent_ctr_d;
    end
  end

  // Lookup side: a purely combinational read of the fetch PC's entry.
  logic [IDX_BITS-1:0] l_idx;
  logic [TAG_W-1:0]    l_tag;
  logic                rd_valid;
  logic [TAG_W-1:0]    rd_tag;
  logic [31:0]         rd_tgt;
  logic [1:0]          rd_ctr;

  assign l_idx = lk_pc[IDX_BITS+1:2];
  assign l_tag = lk_pc[31:IDX_BITS+2];

  // Select the entry seen by the lookup. The forwarding path exists only
  // when the bypass is compiled in.
  always_comb begin
    rd_valid = valid_q[l_idx];
    rd_tag   = tag_q[l_idx];
    rd_tgt   = tgt_q[l_idx];
    rd_ctr   = ctr_q[l_idx];
`ifdef BHT_BYPASS_EN
    if (upd_valid && (u_idx == l_idx)) begin
      rd_valid = ent_valid_d;
      rd_tag   = ent_tag_d;
      rd_tgt   = ent_tgt_d;
      rd_ctr   = ent_ctr_d;
    end
`endif
  end

  assign pred_hit     = rd_valid && (rd_tag == l_tag);
  assign pred_taken   = pred_hit && rd_ctr[1];
  assign pred_next_pc = pred_taken ? rd_tgt : lk_pc + 32'd4;

  // Next-state logic for the statistics counters.
  always_comb begin
    stat_lk_d = stat_lk_q;
    stat_mp_d = stat_mp_q;
    if (lk_valid)                 stat_lk_d = stat_inc(stat_lk_q);
    if (upd_valid && upd_mispred) stat_mp_d = stat_inc(stat_mp_q);
  end

  // Registers for the statistics counters, cleared on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_lk_q <= 16'd0;
      stat_mp_q <= 16'd0;
    end else begin
      stat_lk_q <= stat_lk_d;
      stat_mp_q <= stat_mp_d;
    end
  end

  assign stat_lookups = stat_lk_q;
  assign stat_mispred = stat_mp_q;

endmodule
